chan_err_inject: RTL and testbench
==================================

// Module: chan_err_inject
// PURPOSE
//  Parametrised channel impairment stage between convolutional encoder and Viterbi decoder, generalising the fixed
//  periodic bit-flip channel: W-bit code symbols, selectable error mode (off/periodic/burst/LFSR-random), per-bit mask,
//  bounded injection window, injected-error statistics. Optional BER monitor compares decoder output to delayed source.
// PARAMETERS
//  W         2    code symbol width (rate 1/W encoder output)
//  PER_W     16   width of cfg_period / cfg_burst_len
//  LFSR_W    16   random-mode LFSR width (Fibonacci, maximal-length taps from package)
//  CNT_W     32   statistics counter width
//  BER_DEPTH 64   source-bit FIFO depth for BER monitor (power of 2)
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active-high
//  cfg_mode      in   2       0 OFF, 1 PERIODIC, 2 BURST, 3 RANDOM; sampled on start
//  cfg_period    in   PER_W   PERIODIC/BURST period in symbols
//  cfg_burst_len in   PER_W   BURST: corrupted symbols at start of each period
//  cfg_mask      in   W       bits XORed into a corrupted symbol
//  cfg_thresh    in   LFSR_W  RANDOM: corrupt when lfsr < cfg_thresh
//  cfg_seed      in   LFSR_W  RANDOM: LFSR seed (0 replaced by 1)
//  cfg_window    in   CNT_W   symbols per run; 0 = unbounded
//  start         in   1       pulse: latch cfg, clear stats, begin run
//  in_valid      in   1       encoder symbol valid
//  in_sym        in   W       encoder symbol
//  out_valid     out  1       to decoder enable
//  out_sym       out  W       (possibly corrupted) symbol to decoder
//  busy          out  1       state RUN
//  done          out  1       state DONE
//  sym_cnt       out  CNT_W   symbols processed this run
//  err_sym_cnt   out  CNT_W   symbols corrupted this run
//  err_bit_cnt   out  CNT_W   bits flipped this run (sum of popcount(mask))
// BEHAVIOUR
//  - Reset: state IDLE; out_valid 0, out_sym 0, busy 0, done 0, all counters 0, phase 0, LFSR 1.
//  - Datapath: out_valid/out_sym registered, latency exactly 1 cycle; out_sym = in_sym ^ (inj ? mask_q : 0);
//    out_sym holds when in_valid=0. Symbols always pass (clean) in IDLE and DONE.
//  - FSM IDLE -start-> RUN; RUN -(window!=0 && sym_cnt reaches window)-> DONE; DONE -start-> RUN; start in RUN ignored.
//  - start cycle: cfg latched, stats/phase cleared, LFSR loaded; an in_valid symbol on that cycle passes clean, uncounted.
//  - RUN, per in_valid symbol: inj decided from current phase/LFSR, then phase advances (wraps to 0 at period-1),
//    LFSR steps once. No advance without in_valid.
//    PERIODIC: inj = (phase==0). BURST: inj = (phase < burst_len). RANDOM: inj = (lfsr < thresh). OFF: inj = 0.
//  - period 0 treated as 1 (every symbol). burst_len >= period: every symbol. burst_len 0: none. thresh 0: none.
//  - Symbol that makes sym_cnt == window is processed and counted; DONE asserted next cycle.
//  - Counters saturate at all-ones (no wrap); sym_cnt saturation with window 0 does not end run.
//  - mask 0 with inj: symbol counted in err_sym_cnt, err_bit_cnt adds 0.
//  - rst mid-run: immediate return to reset state; in-flight output dropped.
// CONFIGURATION
//  CHAN_BER_CHECK_EN defined: extra ports src_valid/src_bit (in, encoder input), dec_valid/dec_bit (in, decoder
//   output), cmp_cnt/mis_cnt (out CNT_W), fifo_ovf (out 1, sticky until start/rst). Source bits pushed to
//   BER_DEPTH FIFO while RUN; each dec_valid pops and compares; mis_cnt++ on mismatch; pop on empty ignored;
//   push on full dropped and sets fifo_ovf; simultaneous push/pop on full allowed. start clears FIFO and counts.
//  Undefined: ports and logic absent; core behaviour identical.
// STRUCTURE
//  Package chan_err_pkg: mode enum (MODE_OFF..MODE_RANDOM), state enum (ST_IDLE/ST_RUN/ST_DONE), LFSR tap
//   constants per width, popcount function, saturating-increment function.
//  Sub-module chan_lfsr (LFSR_W, load/seed/step/value); BER FIFO inline.
// TESTING
//  - PERIODIC period=8 mask=2'b01 window=256, continuous valid -> symbols 0,8,..,248 bit0 flipped; err_sym=32, err_bit=32, done.
//  - BURST period=16 len=4 mask=2'b11 window=64 -> symbols 0-3,16-19,32-35,48-51 flipped; err_sym=16, err_bit=32.
//  - RANDOM seed=0xACE1 thresh=0 -> zero errors; thresh=0x8000 twice with same seed -> bit-identical out_sym traces.
//  - Gapped in_valid (1 of 3 cycles), PERIODIC period=4 -> corruption per symbol index, not cycle; latency 1 cycle.
//  - rst asserted at symbol 100 of 256 -> next cycle out_valid=0, counters 0, IDLE; start restarts from phase 0.
//  - CHAN_BER_CHECK_EN: decoder model delay 20 with one forced dec_bit flip over 200 bits -> cmp=200, mis=1, no ovf.

Source files
------------

// File: rtl/chan_err_pkg.sv
// Shared types and helpers for the channel error-injection stage.
package chan_err_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_RANDOM   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Fibonacci tap masks (bit i set = stage i+1 feeds back), maximal length.
  localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] LFSR_TAPS_24 = 64'h0000_0000_00E1_0000;
  localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;

  // Unlisted widths fall back to x^w + x^(w-1) + 1, which is only maximal for some w.
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] t;
    case (w)
      8:       t = LFSR_TAPS_8;
      16:      t = LFSR_TAPS_16;
      24:      t = LFSR_TAPS_24;
      32:      t = LFSR_TAPS_32;
      default: t = (64'd3 << (w - 2));
    endcase
    return t;
  endfunction

  function automatic logic [63:0] popcount(input logic [63:0] v);
    logic [63:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) c = c + 64'd1;
    end
    return c;
  endfunction

  // Adds inc to v, clamping at maxv; written to avoid overflowing the 64-bit sum.
  function automatic logic [63:0] sat_add(input logic [63:0] v, input logic [63:0] inc,
                                          input logic [63:0] maxv);
    logic [63:0] r;
    if ((maxv - v) < inc) r = maxv;
    else                  r = v + inc;
    return r;
  endfunction

endpackage

// File: rtl/chan_lfsr.sv
// Fibonacci LFSR used by the random error mode; a zero seed is replaced by 1.
module chan_lfsr
  import chan_err_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic fb;
  assign fb = ^(value & TAPS);

  // Load takes priority over stepping; the all-zero lock-up state is never entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= LFSR_W'(1);
    end else if (load) begin
      value <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      value <= {value[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/chan_err_inject.sv
// Channel impairment stage: corrupts encoder symbols by mode/mask within a bounded
// window and keeps injection statistics.
// Optional BER monitor (source-bit FIFO vs decoder output) built when CHAN_BER_CHECK_EN is defined.
//
// state   | meaning
// ST_IDLE | after reset, symbols pass clean, waiting for start
// ST_RUN  | injecting errors and counting symbols
// ST_DONE | window exhausted, symbols pass clean, waiting for start
module chan_err_inject
  import chan_err_pkg::*;
#(
  parameter int W         = 2,
  parameter int PER_W     = 16,
  parameter int LFSR_W    = 16,
  parameter int CNT_W     = 32,
  parameter int BER_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [PER_W-1:0]  cfg_burst_len,
  input  logic [W-1:0]      cfg_mask,
  input  logic [LFSR_W-1:0] cfg_thresh,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic [CNT_W-1:0]  cfg_window,
  input  logic              start,
  input  logic              in_valid,
  input  logic [W-1:0]      in_sym,
  output logic              out_valid,
  output logic [W-1:0]      out_sym,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sym_cnt,
  output logic [CNT_W-1:0]  err_sym_cnt,
  output logic [CNT_W-1:0]  err_bit_cnt
`ifdef CHAN_BER_CHECK_EN
  ,
  input  logic              src_valid,
  input  logic              src_bit,
  input  logic              dec_valid,
  input  logic              dec_bit,
  output logic [CNT_W-1:0]  cmp_cnt,
  output logic [CNT_W-1:0]  mis_cnt,
  output logic              fifo_ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state, state_nx;
  mode_e             mode_q;
  logic [PER_W-1:0]  period_q, burst_q, phase, period_eff;
  logic [W-1:0]      mask_q;
  logic [LFSR_W-1:0] thresh_q, lfsr_val;
  logic [CNT_W-1:0]  window_q, sym_cnt_nx;
  logic              start_acc, proc, inj, inj_act;

  assign start_acc  = start && (state != ST_RUN);
  assign proc       = (state == ST_RUN) && in_valid;
  assign period_eff = (period_q == '0) ? PER_W'(1) : period_q;
  assign sym_cnt_nx = CNT_W'(sat_add(64'(sym_cnt), 64'd1, 64'(CNT_MAX)));
  assign inj_act    = proc && inj;
  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);

  chan_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .seed  (cfg_seed),
    .step  (proc),
    .value (lfsr_val)
  );

  // Injection decision from the current phase / LFSR value.
  always_comb begin
    inj = 1'b0;
    case (mode_q)
      MODE_PERIODIC: inj = (phase == '0);
      MODE_BURST:    inj = (phase < burst_q);
      MODE_RANDOM:   inj = (lfsr_val < thresh_q);
      default:       inj = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state: the symbol that fills the window is counted, DONE follows one cycle later.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (proc && (window_q != '0) && (sym_cnt_nx == window_q)) state_nx = ST_DONE;
      ST_DONE: if (start) state_nx = ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath, configuration latch, phase and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_sym     <= '0;
      mode_q      <= MODE_OFF;
      period_q    <= '0;
      burst_q     <= '0;
      mask_q      <= '0;
      thresh_q    <= '0;
      window_q    <= '0;
      phase       <= '0;
      sym_cnt     <= '0;
      err_sym_cnt <= '0;
      err_bit_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_sym <= in_sym ^ (inj_act ? mask_q : '0);
      if (start_acc) begin
        mode_q      <= mode_e'(cfg_mode);
        period_q    <= cfg_period;
        burst_q     <= cfg_burst_len;
        mask_q      <= cfg_mask;
        thresh_q    <= cfg_thresh;
        window_q    <= cfg_window;
        phase       <= '0;
        sym_cnt     <= '0;
        err_sym_cnt <= '0;
        err_bit_cnt <= '0;
      end else if (proc) begin
        sym_cnt <= sym_cnt_nx;
        phase   <= (phase >= period_eff - PER_W'(1)) ? '0 : phase + PER_W'(1);
        if (inj) begin
          err_sym_cnt <= CNT_W'(sat_add(64'(err_sym_cnt), 64'd1, 64'(CNT_MAX)));
          err_bit_cnt <= CNT_W'(sat_add(64'(err_bit_cnt), popcount(64'(mask_q)), 64'(CNT_MAX)));
        end
      end
    end
  end

`ifdef CHAN_BER_CHECK_EN
  localparam int AW = $clog2(BER_DEPTH);

  logic          fifo_mem [BER_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push_req, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req   = (state == ST_RUN) && src_valid;
  assign pop        = dec_valid && !fifo_empty;
  assign push       = push_req && (!fifo_full || pop);

  // FIFO storage; contents need no reset since pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= src_bit;
  end

  // FIFO pointers, comparison counters and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cmp_cnt  <= '0;
      mis_cnt  <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (push_req && !push) fifo_ovf <= 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        cmp_cnt <= CNT_W'(sat_add(64'(cmp_cnt), 64'd1, 64'(CNT_MAX)));
        if (fifo_mem[rd_ptr[AW-1:0]] != dec_bit)
          mis_cnt <= CNT_W'(sat_add(64'(mis_cnt), 64'd1, 64'(CNT_MAX)));
      end
    end
  end
`endif

endmodule

// File: tb/tb_chan_err_inject.sv
// Directed self-checking bench for chan_err_inject (default parameters).
module tb_chan_err_inject;
  import chan_err_pkg::*;

  localparam int W      = 2;
  localparam int PER_W  = 16;
  localparam int LFSR_W = 16;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        cfg_mode = 2'd0;
  logic [PER_W-1:0]  cfg_period = '0;
  logic [PER_W-1:0]  cfg_burst_len = '0;
  logic [W-1:0]      cfg_mask = '0;
  logic [LFSR_W-1:0] cfg_thresh = '0;
  logic [LFSR_W-1:0] cfg_seed = '0;
  logic [CNT_W-1:0]  cfg_window = '0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [W-1:0]      in_sym = '0;
  logic              out_valid, busy, done;
  logic [W-1:0]      out_sym;
  logic [CNT_W-1:0]  sym_cnt, err_sym_cnt, err_bit_cnt;
`ifdef CHAN_BER_CHECK_EN
  logic              src_valid = 1'b0, src_bit = 1'b0, dec_valid = 1'b0, dec_bit = 1'b0;
  logic [CNT_W-1:0]  cmp_cnt, mis_cnt;
  logic              fifo_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chan_err_inject dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mode      (cfg_mode),
    .cfg_period    (cfg_period),
    .cfg_burst_len (cfg_burst_len),
    .cfg_mask      (cfg_mask),
    .cfg_thresh    (cfg_thresh),
    .cfg_seed      (cfg_seed),
    .cfg_window    (cfg_window),
    .start         (start),
    .in_valid      (in_valid),
    .in_sym        (in_sym),
    .out_valid     (out_valid),
    .out_sym       (out_sym),
    .busy          (busy),
    .done          (done),
    .sym_cnt       (sym_cnt),
    .err_sym_cnt   (err_sym_cnt),
    .err_bit_cnt   (err_bit_cnt)
`ifdef CHAN_BER_CHECK_EN
    ,
    .src_valid     (src_valid),
    .src_bit       (src_bit),
    .dec_valid     (dec_valid),
    .dec_bit       (dec_bit),
    .cmp_cnt       (cmp_cnt),
    .mis_cnt       (mis_cnt),
    .fifo_ovf      (fifo_ovf)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; inputs are then zeroed so a zero-latency output would be exposed.
  task automatic send(input logic v, input logic [W-1:0] s);
    in_valid = v;
    in_sym   = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sym   = '0;
    #1;
  endtask

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input int period, input int blen,
                         input logic [W-1:0] mask, input int thresh, input int seed,
                         input int window);
    cfg_mode      = mode;
    cfg_period    = PER_W'(period);
    cfg_burst_len = PER_W'(blen);
    cfg_mask      = mask;
    cfg_thresh    = LFSR_W'(thresh);
    cfg_seed      = LFSR_W'(seed);
    cfg_window    = CNT_W'(window);
  endtask

  function automatic bit exp_inj(input logic [1:0] mode, input int idx, input int period,
                                 input int blen);
    int p;
    p = (period == 0) ? 1 : period;
    if (mode == 2'd1) return (idx % p) == 0;
    if (mode == 2'd2) return (idx % p) < blen;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] sym_of(input int i);
    return W'(i * 3 + i / 4);
  endfunction

  // Full windowed run against the periodic/burst model; returns mismatching symbols.
  task automatic run_directed(input logic [1:0] mode, input int period, input int blen,
                              input logic [W-1:0] mask, input int n, output int bad);
    logic [W-1:0] s, e;
    set_cfg(mode, period, blen, mask, 0, 0, n);
    do_start();
    bad = 0;
    for (int i = 0; i < n; i++) begin
      s = sym_of(i);
      send(1'b1, s);
      e = s ^ (exp_inj(mode, i, period, blen) ? mask : '0);
      if (out_valid !== 1'b1 || out_sym !== e) bad++;
    end
  endtask

  // Random-mode run of 64 symbols, recording the output trace.
  task automatic run_random(input int thresh, input int seed, output logic [W-1:0] tr [64],
                            output int esym, output int ebit);
    set_cfg(2'd3, 0, 0, 2'b10, thresh, seed, 64);
    do_start();
    for (int i = 0; i < 64; i++) begin
      send(1'b1, sym_of(i));
      tr[i] = out_sym;
    end
    esym = int'(err_sym_cnt);
    ebit = int'(err_bit_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, ea, eb, ec, ba, bb, bc, diff;
    logic [W-1:0] tra [64];
    logic [W-1:0] trb [64];
    logic [W-1:0] trc [64];
    logic [W-1:0] s, e, prev;
    int k;

    // Reset, with traffic present.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b1, 2'b11);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_sym", out_sym, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_sym_cnt", sym_cnt, 0);
    rst = 1'b0;

    // IDLE passes symbols clean.
    set_cfg(2'd1, 1, 0, 2'b11, 0, 0, 0);
    send(1'b1, 2'b10);
    check_val("idle_clean", out_sym, 2'b10);
    check_val("idle_sym_cnt", sym_cnt, 0);

    // PERIODIC period 8, window 256, with a start pulse mid-run that must be ignored.
    set_cfg(2'd1, 8, 0, 2'b01, 0, 0, 256);
    do_start();
    check_val("per_busy_start", busy, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      s = sym_of(i);
      if (i == 100) begin start = 1'b1; cfg_mask = 2'b11; end
      send(1'b1, s);
      start = 1'b0;
      cfg_mask = 2'b01;
      e = s ^ (((i % 8) == 0) ? 2'b01 : 2'b00);
      if (out_valid !== 1'b1 || out_sym !== e) bad++;
      if (i == 254) check_val("per_busy_before_last", {busy, done}, 2'b10);
    end
    check_val("per_trace", bad, 0);
    check_val("per_sym_cnt", sym_cnt, 256);
    check_val("per_err_sym", err_sym_cnt, 32);
    check_val("per_err_bit", err_bit_cnt, 32);
    check_val("per_done", {busy, done}, 2'b01);
    send(1'b1, 2'b00);
    check_val("done_clean", out_sym, 2'b00);
    check_val("done_sym_cnt_hold", sym_cnt, 256);

    // BURST period 16 len 4 mask 11, window 64.
    run_directed(2'd2, 16, 4, 2'b11, 64, bad);
    check_val("burst_trace", bad, 0);
    check_val("burst_err_sym", err_sym_cnt, 16);
    check_val("burst_err_bit", err_bit_cnt, 32);
    check_val("burst_done", done, 1);

    // Boundary configurations.
    run_directed(2'd1, 0, 0, 2'b01, 4, bad);
    check_val("per0_trace", bad, 0);
    check_val("per0_err_sym", err_sym_cnt, 4);
    run_directed(2'd2, 3, 5, 2'b11, 6, bad);
    check_val("burst_long_trace", bad, 0);
    check_val("burst_long_err_bit", err_bit_cnt, 12);
    run_directed(2'd2, 4, 0, 2'b11, 8, bad);
    check_val("burst_len0_err_sym", err_sym_cnt, 0);
    run_directed(2'd1, 2, 0, 2'b00, 4, bad);
    check_val("mask0_err_sym", err_sym_cnt, 2);
    check_val("mask0_err_bit", err_bit_cnt, 0);
    run_directed(2'd0, 1, 9, 2'b11, 5, bad);
    check_val("off_trace", bad, 0);
    check_val("off_err_sym", err_sym_cnt, 0);

    // RANDOM: thresh 0 never corrupts.
    run_random(0, 16'hACE1, tra, ea, ba);
    diff = 0;
    for (int i = 0; i < 64; i++) if (tra[i] !== sym_of(i)) diff++;
    check_val("rand_t0_trace", diff, 0);
    check_val("rand_t0_err_sym", ea, 0);

    // RANDOM: same seed reproduces the trace; seed 0 behaves as seed 1.
    run_random(16'h8000, 16'hACE1, tra, ea, ba);
    run_random(16'h8000, 16'hACE1, trb, eb, bb);
    diff = 0;
    for (int i = 0; i < 64; i++) if (tra[i] !== trb[i]) diff++;
    check_val("rand_repeat_trace", diff, 0);
    check_val("rand_repeat_err", eb, ea);
    check_val("rand_some_err", (ea > 0) && (ea < 64), 1);
    check_val("rand_err_bit", ba, ea);
    diff = 0;
    for (int i = 0; i < 64; i++) if ((tra[i] ^ sym_of(i)) !== ((tra[i] == sym_of(i)) ? 2'b00 : 2'b10)) diff++;
    check_val("rand_mask_only", diff, 0);
    run_random(16'h8000, 0, trb, eb, bb);
    run_random(16'h8000, 1, trc, ec, bc);
    diff = 0;
    for (int i = 0; i < 64; i++) if (trb[i] !== trc[i]) diff++;
    check_val("rand_seed0_as_1", diff, 0);

    // Gapped valid, PERIODIC period 4: corruption follows symbol index, output holds in gaps.
    set_cfg(2'd1, 4, 0, 2'b10, 0, 0, 30);
    do_start();
    k = 0;
    bad = 0;
    prev = '0;
    for (int c = 0; c < 90; c++) begin
      s = sym_of(c);
      send((c % 3) == 0, s);
      if ((c % 3) == 0) begin
        prev = s ^ (((k % 4) == 0) ? 2'b10 : 2'b00);
        k++;
      end
      if (out_valid !== ((c % 3) == 0) || out_sym !== prev) bad++;
    end
    check_val("gap_trace", bad, 0);
    check_val("gap_sym_cnt", sym_cnt, 30);
    check_val("gap_err_sym", err_sym_cnt, 8);
    check_val("gap_done", done, 1);

    // Reset at symbol 100 of 256, then restart from phase 0.
    set_cfg(2'd1, 8, 0, 2'b01, 0, 0, 256);
    do_start();
    for (int i = 0; i < 100; i++) send(1'b1, sym_of(i));
    check_val("pre_rst_err_sym", err_sym_cnt, 13);
    rst = 1'b1;
    send(1'b1, 2'b11);
    rst = 1'b0;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_out_sym", out_sym, 0);
    check_val("mid_rst_cnts", {sym_cnt, err_sym_cnt, err_bit_cnt}, 0);
    check_val("mid_rst_state", {busy, done}, 2'b00);
    do_start();
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      s = sym_of(i);
      send(1'b1, s);
      if (out_sym !== (s ^ (((i % 8) == 0) ? 2'b01 : 2'b00))) bad++;
    end
    check_val("restart_trace", bad, 0);
    check_val("restart_err_sym", err_sym_cnt, 2);

`ifdef CHAN_BER_CHECK_EN
    begin
      logic sv [0:255];
      logic sb [0:255];
      set_cfg(2'd0, 1, 0, 2'b00, 0, 0, 0);
      do_start();
      for (int c = 0; c < 256; c++) begin
        sv[c] = (c < 200);
        sb[c] = logic'((c * 7 + c / 5) % 2);
      end
      for (int c = 0; c < 240; c++) begin
        src_valid = sv[c];
        src_bit   = sb[c];
        dec_valid = (c >= 20) ? sv[c-20] : 1'b0;
        dec_bit   = (c >= 20) ? (sb[c-20] ^ ((c - 20) == 57)) : 1'b0;
        @(posedge clk);
        #1;
      end
      src_valid = 1'b0;
      dec_valid = 1'b0;
      check_val("ber_cmp", cmp_cnt, 200);
      check_val("ber_mis", mis_cnt, 1);
      check_val("ber_ovf", fifo_ovf, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
